// File: rtl/i2c_pkg.sv
// Shared definitions for the camera-config I2C target: FSM state codes,
// R/W bit values and the default 7-bit target address.
`timescale 1ns/1ps
package i2c_pkg;

    // Default 7-bit target address (bus bytes 0xBA write / 0xBB read)
    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h5D;

    // Value of the R/W bit in the address byte
    localparam logic I2C_WR = 1'b0;
    localparam logic I2C_RD = 1'b1;

    // FSM state type and codes
    typedef logic [3:0] i2c_state_t;

    localparam i2c_state_t ST_IDLE     = 4'd0;
    localparam i2c_state_t ST_ADDR     = 4'd1;
    localparam i2c_state_t ST_ADDR_ACK = 4'd2;
    localparam i2c_state_t ST_SUB      = 4'd3;
    localparam i2c_state_t ST_SUB_ACK  = 4'd4;
    localparam i2c_state_t ST_WHI      = 4'd5;
    localparam i2c_state_t ST_WHI_ACK  = 4'd6;
    localparam i2c_state_t ST_WLO      = 4'd7;
    localparam i2c_state_t ST_WLO_ACK  = 4'd8;
    localparam i2c_state_t ST_RHI      = 4'd9;
    localparam i2c_state_t ST_RHI_ACK  = 4'd10;
    localparam i2c_state_t ST_RLO      = 4'd11;
    localparam i2c_state_t ST_RLO_ACK  = 4'd12;

endpackage

// File: rtl/i2c_bus_sync.sv
// Bus input conditioning for the I2C target: 2-FF synchronizers on SCL and
// SDA, a history stage for edge detection, and START/STOP recognition.
`timescale 1ns/1ps
module i2c_bus_sync (
    input  logic CLOCK,
    input  logic RESET,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start,
    output logic stop
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_hist;
    logic       sda_hist;

    // Synchronize both lines and keep one cycle of history; idle bus reads high
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_hist <= scl_sync[1];
            sda_hist <= sda_sync[1];
        end
    end

    assign scl_rise = scl_sync[1] & ~scl_hist;
    assign scl_fall = ~scl_sync[1] & scl_hist;
    assign sda_s    = sda_sync[1];

    // START/STOP are SDA edges while SCL is high on both sides of the edge
    assign start = scl_sync[1] & scl_hist & sda_hist & ~sda_sync[1];
    assign stop  = scl_sync[1] & scl_hist & ~sda_hist & sda_sync[1];

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target for the camera configuration bus. Decodes 4-byte write frames
// (address, sub-address, data MSB, data LSB) into write strobes, and serves
// register reads from externally stored data addressed by RD_ADDR.
`timescale 1ns/1ps
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = I2C_DEFAULT_ADDR
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        I2C_SCLK,
    inout  wire         I2C_SDAT,
    output logic [7:0]  WR_ADDR,
    output logic [15:0] WR_DATA,
    output logic        WR_STROBE,
    output logic [7:0]  RD_ADDR,
    input  logic [15:0] RD_DATA,
    output logic        BUSY,
    output logic        ACK
);

    logic       scl_rise;
    logic       scl_fall;
    logic       sda_s;
    logic       start;
    logic       stop;

    i2c_state_t state;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] rx_next;
    logic [6:0] tx_shift;
    logic       sda_oe;
    logic       ack_phase;
    logic       rw_bit;
    logic       master_nack;
    logic [7:0] data_msb;
    logic [7:0] data_lsb;
    logic [7:0] ptr;
    logic [7:0] wr_addr_q;
    logic [15:0] wr_data_q;
    logic       wr_strobe_q;
    logic       busy_q;
    logic       ack_flag;

    i2c_bus_sync u_sync (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .scl_in   (I2C_SCLK),
        .sda_in   (I2C_SDAT),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda_s    (sda_s),
        .start    (start),
        .stop     (stop)
    );

    // Byte being completed by the current SCL rising edge
    assign rx_next = {rx_shift, sda_s};

    // Bus FSM: receive shifting, ACK generation, read transmission and pointer
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            bit_cnt     <= 3'd0;
            rx_shift    <= 7'd0;
            tx_shift    <= 7'd0;
            sda_oe      <= 1'b0;
            ack_phase   <= 1'b0;
            rw_bit      <= I2C_WR;
            master_nack <= 1'b0;
            data_msb    <= 8'd0;
            data_lsb    <= 8'd0;
            ptr         <= 8'd0;
            wr_addr_q   <= 8'd0;
            wr_data_q   <= 16'd0;
            wr_strobe_q <= 1'b0;
            busy_q      <= 1'b0;
            ack_flag    <= 1'b0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (stop) begin
                state     <= ST_IDLE;
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
                busy_q    <= 1'b0;
            end else if (start) begin
                state     <= ST_ADDR;
                bit_cnt   <= 3'd0;
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
                ack_flag  <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR, ST_SUB, ST_WHI, ST_WLO: begin
                        if (scl_rise) begin
                            rx_shift <= rx_next[6:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ack_phase <= 1'b0;
                                case (state)
                                    ST_ADDR: begin
                                        if (rx_next[7:1] == SLAVE_ADDR) begin
                                            rw_bit <= rx_next[0];
                                            busy_q <= 1'b1;
                                            state  <= ST_ADDR_ACK;
                                        end else begin
                                            state  <= ST_IDLE;
                                        end
                                    end
                                    ST_SUB: begin
                                        ptr   <= rx_next;
                                        state <= ST_SUB_ACK;
                                    end
                                    ST_WHI: begin
                                        data_msb <= rx_next;
                                        state    <= ST_WHI_ACK;
                                    end
                                    default: begin
                                        data_lsb <= rx_next;
                                        state    <= ST_WLO_ACK;
                                    end
                                endcase
                            end
                        end
                    end

                    ST_ADDR_ACK, ST_SUB_ACK, ST_WHI_ACK, ST_WLO_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe    <= 1'b1;
                                ack_phase <= 1'b1;
                            end else begin
                                sda_oe    <= 1'b0;
                                ack_phase <= 1'b0;
                                bit_cnt   <= 3'd0;
                                case (state)
                                    ST_ADDR_ACK: begin
                                        if (rw_bit == I2C_RD) begin
                                            state    <= ST_RHI;
                                            tx_shift <= RD_DATA[14:8];
                                            sda_oe   <= ~RD_DATA[15];
                                        end else begin
                                            state    <= ST_SUB;
                                        end
                                    end
                                    ST_SUB_ACK: state <= ST_WHI;
                                    ST_WHI_ACK: state <= ST_WLO;
                                    default: begin
                                        wr_strobe_q <= 1'b1;
                                        wr_addr_q   <= ptr;
                                        wr_data_q   <= {data_msb, data_lsb};
                                        ptr         <= ptr + 8'd1;
                                        state       <= ST_WHI;
                                    end
                                endcase
                            end
                        end
                    end

                    ST_RHI, ST_RLO: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 3'd0) begin
                                sda_oe <= 1'b0;
                                state  <= (state == ST_RHI) ? ST_RHI_ACK : ST_RLO_ACK;
                            end else begin
                                sda_oe   <= ~tx_shift[6];
                                tx_shift <= {tx_shift[5:0], 1'b0};
                            end
                        end
                    end

                    ST_RHI_ACK, ST_RLO_ACK: begin
                        if (scl_rise) begin
                            master_nack <= sda_s;
                            if (state == ST_RHI_ACK && sda_s) begin
                                ack_flag <= 1'b1;
                            end
                            if (state == ST_RLO_ACK) begin
                                ptr <= ptr + 8'd1;
                            end
                        end else if (scl_fall) begin
                            bit_cnt <= 3'd0;
                            if (master_nack) begin
                                state <= ST_IDLE;
                            end else if (state == ST_RHI_ACK) begin
                                state    <= ST_RLO;
                                tx_shift <= RD_DATA[6:0];
                                sda_oe   <= ~RD_DATA[7];
                            end else begin
                                state    <= ST_RHI;
                                tx_shift <= RD_DATA[14:8];
                                sda_oe   <= ~RD_DATA[15];
                            end
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Open-drain output; reset releases the line combinationally
    assign I2C_SDAT = (sda_oe && !RESET) ? 1'b0 : 1'bz;

    assign WR_ADDR   = wr_addr_q;
    assign WR_DATA   = wr_data_q;
    assign WR_STROBE = wr_strobe_q;
    assign RD_ADDR   = ptr;
    assign BUSY      = busy_q;
    assign ACK       = ack_flag;

endmodule
